sb_cfg_shadow: RTL and testbench

Parametrised switch block for the FPGA routing fabric with a double-buffered configuration chain. It connects a top Y channel and a left X channel of `W` tracks each. Fixed short tracks pass straight through. Every other output track is a 2:1 mux that picks either a grid pin or the opposite channel. The configuration is shifted serially into a shadow register and applied atomically on commit, so routing never glitches during reprogramming; a bit counter checks that exactly the required number of bits was loaded.

---
 rtl/sb_cfg_pkg.sv | 23 ++
 rtl/sb_cfg_chain.sv | 93 +++++++++
 rtl/sb_cfg_shadow.sv | 71 +++++++
 tb/tb_sb_cfg_shadow.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_cfg_pkg.sv
// sb_cfg_pkg: shared types and helpers for the shadowed
// switch-block configuration chain.
package sb_cfg_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_SHIFT,
    CFG_READY,
    CFG_OVER
  } cfg_state_e;

  localparam int SEL_OFS      = 0;
  localparam int EN_OFS       = 1;
  localparam int BITS_PER_MUX = 2;

  function automatic int sb_cfg_bits(
    input int w,
    input int nshort
  );
    return 2 * BITS_PER_MUX * (w - nshort);
  endfunction

endpackage

// File: rtl/sb_cfg_chain.sv
// sb_cfg_chain: serial shadow register, bit counter,
// load-state FSM and atomically committed active register.
module sb_cfg_chain
  import sb_cfg_pkg::*;
#(
  parameter int CFG_BITS = 24
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_head,
  input  logic                i_shift_en,
  input  logic                i_commit,
  input  logic                i_clear,
  output logic [CFG_BITS-1:0] o_active,
  output logic                o_tail,
  output logic                o_ready,
  output logic                o_err
);

  localparam int CW = $clog2(CFG_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);
  localparam logic [CW-1:0] CNT_OVER = CW'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] r_active;
  logic [CW-1:0]       r_cnt;
  logic                r_err;

  cfg_state_e          w_state;
  logic [CFG_BITS-1:0] w_shadow_nxt;
  logic [CFG_BITS-1:0] w_active_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_err_nxt;

  // The counter is the state register; decode it into states.
  always_comb begin
    w_state = CFG_SHIFT;
    if (r_cnt == '0) begin
      w_state = CFG_IDLE;
    end else if (r_cnt == CNT_FULL) begin
      w_state = CFG_READY;
    end else if (r_cnt == CNT_OVER) begin
      w_state = CFG_OVER;
    end
  end

  // Next state: clear wins, then shift and commit side by side.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_active_nxt = r_active;
    w_cnt_nxt    = r_cnt;
    w_err_nxt    = r_err;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else begin
      if (i_shift_en) begin
        w_shadow_nxt = {r_shadow[CFG_BITS-2:0], i_head};
        if (w_state != CFG_OVER) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      if (i_commit) begin
        if (w_state == CFG_READY && !i_shift_en) begin
          w_active_nxt = r_shadow;
          w_cnt_nxt    = '0;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      r_active <= w_active_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign o_active = r_active;
  assign o_tail   = r_shadow[CFG_BITS-1];
  assign o_ready  = (w_state == CFG_READY);
  assign o_err    = r_err;

endmodule

// File: rtl/sb_cfg_shadow.sv
// sb_cfg_shadow: switch block joining top Y and left X
// channels; shorts are fixed, muxed tracks use active config.
module sb_cfg_shadow
  import sb_cfg_pkg::*;
#(
  parameter int W      = 9,
  parameter int NSHORT = 3
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic [0:W-1]        chany_top_in,
  input  logic [0:W-1]        chanx_left_in,
  input  logic [0:W-NSHORT-1] top_pin_in,
  input  logic [0:W-NSHORT-1] left_pin_in,
  output logic [0:W-1]        chany_top_out,
  output logic [0:W-1]        chanx_left_out,
  input  logic                ccff_head,
  input  logic                cfg_shift_en,
  input  logic                cfg_commit,
  input  logic                cfg_clear,
  output logic                ccff_tail,
  output logic                cfg_ready,
  output logic                cfg_err
);

  localparam int M        = W - NSHORT;
  localparam int CFG_BITS = sb_cfg_bits(W, NSHORT);

  if (NSHORT < 1 || NSHORT >= W - 1) begin : g_bad_param
    $error("sb_cfg_shadow: need 1 <= NSHORT < W-1");
  end

  logic [CFG_BITS-1:0] w_active;

  sb_cfg_chain #(
    .CFG_BITS (CFG_BITS)
  ) u_chain (
    .i_clk      (prog_clk),
    .i_rst_n    (prog_reset_n),
    .i_head     (ccff_head),
    .i_shift_en (cfg_shift_en),
    .i_commit   (cfg_commit),
    .i_clear    (cfg_clear),
    .o_active   (w_active),
    .o_tail     (ccff_tail),
    .o_ready    (cfg_ready),
    .o_err      (cfg_err)
  );

  for (genvar j = 1; j <= NSHORT; j++) begin : g_short
    assign chany_top_out[W-j]  = chanx_left_in[j];
    assign chanx_left_out[W-j] = chany_top_in[j];
  end

  for (genvar k = 0; k < M; k++) begin : g_mux
    localparam int CI = (k == 0) ? 0 : W - k;
    localparam int BT = BITS_PER_MUX * k;
    localparam int BL = BITS_PER_MUX * (M + k);

    assign chany_top_out[k] =
      !w_active[BT+EN_OFS] ? 1'b0 :
      w_active[BT+SEL_OFS] ? chanx_left_in[CI] :
      top_pin_in[k];

    assign chanx_left_out[k] =
      !w_active[BL+EN_OFS] ? 1'b0 :
      w_active[BL+SEL_OFS] ? chany_top_in[CI] :
      left_pin_in[k];
  end

endmodule

// File: tb/tb_sb_cfg_shadow.sv
// tb_sb_cfg_shadow: randomized and directed checks of the
// shadowed switch block against a queue-based model.
module tb_sb_cfg_shadow;

  localparam int W   = 9;
  localparam int NS  = 3;
  localparam int M   = W - NS;
  localparam int CB  = 4 * M;
  localparam int W2  = 12;
  localparam int NS2 = 4;
  localparam int M2  = W2 - NS2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [0:W-1] ty_in, lx_in, ty_out, lx_out;
  logic [0:M-1] tpin, lpin;
  logic head, shift, commit, clear;
  logic tail, ready, err;

  logic [0:W2-1] ty2_in, lx2_in, ty2_out, lx2_out;
  logic [0:M2-1] tpin2, lpin2;
  logic head2, shift2, commit2, clear2;
  logic tail2, ready2, err2;

  int n_checks = 0;
  int n_fail   = 0;

  bit q[$];
  int m_cnt;
  bit m_act[CB];
  bit m_err;

  sb_cfg_shadow u_dut (
    .prog_clk       (clk),
    .prog_reset_n   (rst_n),
    .chany_top_in   (ty_in),
    .chanx_left_in  (lx_in),
    .top_pin_in     (tpin),
    .left_pin_in    (lpin),
    .chany_top_out  (ty_out),
    .chanx_left_out (lx_out),
    .ccff_head      (head),
    .cfg_shift_en   (shift),
    .cfg_commit     (commit),
    .cfg_clear      (clear),
    .ccff_tail      (tail),
    .cfg_ready      (ready),
    .cfg_err        (err)
  );

  sb_cfg_shadow #(
    .W      (W2),
    .NSHORT (NS2)
  ) u_dut2 (
    .prog_clk       (clk),
    .prog_reset_n   (rst_n),
    .chany_top_in   (ty2_in),
    .chanx_left_in  (lx2_in),
    .top_pin_in     (tpin2),
    .left_pin_in    (lpin2),
    .chany_top_out  (ty2_out),
    .chanx_left_out (lx2_out),
    .ccff_head      (head2),
    .cfg_shift_en   (shift2),
    .cfg_commit     (commit2),
    .cfg_clear      (clear2),
    .ccff_tail      (tail2),
    .cfg_ready      (ready2),
    .cfg_err        (err2)
  );

  // Shadow bit i is the bit shifted in i shifts ago.
  function automatic bit sh(int i);
    if (i < q.size()) return q[q.size()-1-i];
    return 1'b0;
  endfunction

  function automatic void model_edge(
    bit rn, bit s, bit b, bit c, bit cl
  );
    if (!rn) begin
      q.delete();
      m_cnt = 0;
      m_err = 1'b0;
      foreach (m_act[i]) m_act[i] = 1'b0;
    end else if (cl) begin
      m_cnt = 0;
    end else begin
      if (c) begin
        if (m_cnt == CB && !s) begin
          foreach (m_act[i]) m_act[i] = sh(i);
          m_cnt = 0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (s) begin
        q.push_back(b);
        if (q.size() > CB) void'(q.pop_front());
        if (m_cnt < CB + 1) m_cnt++;
      end
    end
  endfunction

  function automatic logic exp_mux(
    int n, logic ch, logic pin
  );
    if (!m_act[2*n+1]) return 1'b0;
    return m_act[2*n] ? ch : pin;
  endfunction

  function automatic logic [0:W-1] exp_ty();
    logic [0:W-1] r;
    r = '0;
    for (int k = 0; k < M; k++)
      r[k] = exp_mux(k, lx_in[(k == 0) ? 0 : W-k], tpin[k]);
    for (int j = 1; j <= NS; j++)
      r[W-j] = lx_in[j];
    return r;
  endfunction

  function automatic logic [0:W-1] exp_lx();
    logic [0:W-1] r;
    r = '0;
    for (int k = 0; k < M; k++)
      r[k] = exp_mux(M+k, ty_in[(k == 0) ? 0 : W-k], lpin[k]);
    for (int j = 1; j <= NS; j++)
      r[W-j] = ty_in[j];
    return r;
  endfunction

  task automatic shuffle();
    logic [31:0] r;
    r = $urandom;
    {ty_in, lx_in, tpin, lpin} = r[29:0];
    r = $urandom;
    {ty2_in, lx2_in} = r[23:0];
    r = $urandom;
    {tpin2, lpin2} = r[15:0];
  endtask

  task automatic step(
    input bit s, input bit b, input bit c,
    input bit cl, input bit rn
  );
    rst_n  = rn;
    shift  = s;
    head   = b;
    commit = c;
    clear  = cl;
    shuffle();
    @(posedge clk);
    model_edge(rn, s, b, c, cl);
    #1;
  endtask

  task automatic step2(
    input bit s, input bit b, input bit c, input bit rn
  );
    rst_n   = rn;
    shift2  = s;
    head2   = b;
    commit2 = c;
    clear2  = 1'b0;
    shuffle();
    @(posedge clk);
    #1;
    shift2  = 1'b0;
    commit2 = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'b0);
      n_checks++;
      if (ty_out[0:M-1] !== '0 || lx_out[0:M-1] !== '0) begin
        n_fail++;
        $display("FAIL reset_mux: top %b left %b want 0",
                 ty_out[0:M-1], lx_out[0:M-1]);
      end
      n_checks++;
      if (ty_out[8] !== lx_in[1]) begin
        n_fail++;
        $display("FAIL reset_short: got %b want %b",
                 ty_out[8], lx_in[1]);
      end
      n_checks++;
      if ({tail, ready, err} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_status: got %b want 000",
                 {tail, ready, err});
      end
      n_checks++;
      if (ty_out !== exp_ty() || lx_out !== exp_lx()) begin
        n_fail++;
        $display("FAIL reset_route: got %b/%b want %b/%b",
                 ty_out, lx_out, exp_ty(), exp_lx());
      end
      n_checks++;
      if (ty2_out[11] !== lx2_in[1]) begin
        n_fail++;
        $display("FAIL reset_short2: got %b want %b",
                 ty2_out[11], lx2_in[1]);
      end
    end
  endtask

  task automatic test_load_commit();
    logic [CB-1:0] cfg;
    cfg = '0;
    cfg[0]  = 1'b1;
    cfg[1]  = 1'b1;
    cfg[13] = 1'b1;
    step(0, 0, 0, 0, 1);
    for (int i = CB - 1; i >= 0; i--) begin
      step(1, cfg[i], 0, 0, 1);
      if (i == 1) begin
        n_checks++;
        if (ready !== 1'b0) begin
          n_fail++;
          $display("FAIL load_early_ready: got %b want 0",
                   ready);
        end
      end
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_ready: got %b want 1", ready);
    end
    n_checks++;
    if (ty_out[0] !== 1'b0 || tail !== sh(CB-1)) begin
      n_fail++;
      $display("FAIL load_preview: top0 %b tail %b want 0 %b",
               ty_out[0], tail, sh(CB-1));
    end
    step(0, 0, 1, 0, 1);
    n_checks++;
    if (ty_out[0] !== lx_in[0]) begin
      n_fail++;
      $display("FAIL commit_top0: got %b want %b",
               ty_out[0], lx_in[0]);
    end
    n_checks++;
    if (lx_out[0] !== lpin[0]) begin
      n_fail++;
      $display("FAIL commit_left0: got %b want %b",
               lx_out[0], lpin[0]);
    end
    n_checks++;
    if (ready !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_status: rdy %b err %b want 0 0",
               ready, err);
    end
    for (int i = 0; i < 4; i++) begin
      shuffle();
      #1;
      n_checks++;
      if (ty_out !== exp_ty() || lx_out !== exp_lx()) begin
        n_fail++;
        $display("FAIL commit_route: got %b/%b want %b/%b",
                 ty_out, lx_out, exp_ty(), exp_lx());
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < CB + 1; i++) begin
      step(1, 1'($urandom), 0, 0, 1);
      if (i == CB - 1 || i == CB) begin
        n_checks++;
        if (ready !== (i == CB - 1)) begin
          n_fail++;
          $display("FAIL over_ready%0d: got %b want %b",
                   i, ready, (i == CB - 1));
        end
      end
    end
    step(0, 0, 1, 0, 1);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL over_err: got %b want 1", err);
    end
    n_checks++;
    if (ty_out !== exp_ty() || lx_out !== exp_lx()
        || ty_out[0] !== lx_in[0]) begin
      n_fail++;
      $display("FAIL over_active: got %b/%b want %b/%b",
               ty_out, lx_out, exp_ty(), exp_lx());
    end
    step(1, 1, 1, 1, 1);
    n_checks++;
    if (ready !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_status: rdy %b err %b want 0 1",
               ready, err);
    end
    n_checks++;
    if (tail !== sh(CB-1)) begin
      n_fail++;
      $display("FAIL clear_noshift: got %b want %b",
               tail, sh(CB-1));
    end
    for (int i = 0; i < CB; i++) begin
      step(1, 1'($urandom), 0, 0, 1);
      if (i >= CB - 2) begin
        n_checks++;
        if (ready !== (i == CB - 1)) begin
          n_fail++;
          $display("FAIL clear_recount%0d: got %b want %b",
                   i, ready, (i == CB - 1));
        end
      end
    end
  endtask

  task automatic test_collision();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < CB - 1; i++) step(1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 1);
    n_checks++;
    if (ready !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_status: rdy %b err %b want 1 1",
               ready, err);
    end
    n_checks++;
    if (ty_out[0:M-1] !== '0 || lx_out[0:M-1] !== '0) begin
      n_fail++;
      $display("FAIL coll_nocommit: got %b/%b want 0",
               ty_out[0:M-1], lx_out[0:M-1]);
    end
    step(0, 0, 1, 0, 1);
    n_checks++;
    if (ty_out !== exp_ty() || lx_out !== exp_lx()
        || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_commit: got %b/%b want %b/%b",
               ty_out, lx_out, exp_ty(), exp_lx());
    end
  endtask

  task automatic test_mid_reset();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    n_checks++;
    if ({tail, ready, err} !== 3'b000
        || ty_out[0:M-1] !== '0) begin
      n_fail++;
      $display("FAIL mreset_state: got %b %b want 000 0",
               {tail, ready, err}, ty_out[0:M-1]);
    end
    for (int i = 0; i < CB; i++) begin
      step(1, 0, 0, 0, 1);
      n_checks++;
      if (tail !== 1'b0) begin
        n_fail++;
        $display("FAIL mreset_tail%0d: got %b want 0",
                 i, tail);
      end
      n_checks++;
      if (ready !== (i == CB - 1)) begin
        n_fail++;
        $display("FAIL mreset_ready%0d: got %b want %b",
                 i, ready, (i == CB - 1));
      end
    end
  endtask

  task automatic test_random();
    bit s, c, cl, rn;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 3) != 0);
      c  = (m_cnt == CB) ? 1'($urandom_range(0, 1))
                         : ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 29) == 0);
      rn = ($urandom_range(0, 99) != 0);
      step(s, 1'($urandom), c, cl, rn);
      n_checks++;
      if (ty_out !== exp_ty() || lx_out !== exp_lx()) begin
        n_fail++;
        $display("FAIL rnd_route%0d: got %b/%b want %b/%b",
                 i, ty_out, lx_out, exp_ty(), exp_lx());
      end
      n_checks++;
      if (tail !== sh(CB-1)) begin
        n_fail++;
        $display("FAIL rnd_tail%0d: got %b want %b",
                 i, tail, sh(CB-1));
      end
      n_checks++;
      if (ready !== (m_cnt == CB)) begin
        n_fail++;
        $display("FAIL rnd_ready%0d: got %b want %b",
                 i, ready, (m_cnt == CB));
      end
      n_checks++;
      if (err !== m_err) begin
        n_fail++;
        $display("FAIL rnd_err%0d: got %b want %b",
                 i, err, m_err);
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [31:0] cfg;
    cfg = '0;
    cfg[31] = 1'b1;
    cfg[3]  = 1'b1;
    cfg[2]  = 1'b1;
    step2(0, 0, 0, 0);
    step2(0, 0, 0, 1);
    for (int i = 31; i >= 0; i--) begin
      step2(1, cfg[i], 0, 1);
      if (i <= 1) begin
        n_checks++;
        if (tail2 !== (i == 0)) begin
          n_fail++;
          $display("FAIL p_tail%0d: got %b want %b",
                   i, tail2, (i == 0));
        end
        n_checks++;
        if (ready2 !== (i == 0)) begin
          n_fail++;
          $display("FAIL p_ready%0d: got %b want %b",
                   i, ready2, (i == 0));
        end
      end
    end
    step2(0, 0, 1, 1);
    n_checks++;
    if (ready2 !== 1'b0 || err2 !== 1'b0) begin
      n_fail++;
      $display("FAIL p_commit: rdy %b err %b want 0 0",
               ready2, err2);
    end
    for (int i = 0; i < 4; i++) begin
      shuffle();
      #1;
      n_checks++;
      if (ty2_out[1] !== lx2_in[11]) begin
        n_fail++;
        $display("FAIL p_top1: got %b want %b",
                 ty2_out[1], lx2_in[11]);
      end
      n_checks++;
      if (ty2_out[11] !== lx2_in[1]) begin
        n_fail++;
        $display("FAIL p_short: got %b want %b",
                 ty2_out[11], lx2_in[1]);
      end
      n_checks++;
      if (ty2_out[0] !== 1'b0 || lx2_out[7] !== lpin2[7]) begin
        n_fail++;
        $display("FAIL p_mux: t0 %b l7 %b want 0 %b",
                 ty2_out[0], lx2_out[7], lpin2[7]);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    {shift, head, commit, clear} = '0;
    {shift2, head2, commit2, clear2} = '0;
    shuffle();
    m_cnt = 0;
    m_err = 1'b0;
    foreach (m_act[i]) m_act[i] = 1'b0;
    test_reset();
    test_load_commit();
    test_overflow();
    test_collision();
    test_mid_reset();
    test_random();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
